pll_reconfig_ctrl: RTL and testbench

//  Dynamic-reconfiguration sequencer for the Gowin PLL on GW5AST. Drives MDSEL/ODSELn/RESET/ENCLKn,

---
 rtl/pll_cfg_pkg.sv | 12 +
 rtl/pll_reconfig_ctrl_if.sv | 12 +
 rtl/pll_lock_filter.sv | 27 ++
 rtl/pll_reconfig_ctrl.sv | 111 +++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: FSM states, divider widths and table indexing shared by the PLL reconfig controller
package pll_cfg_pkg;
  localparam int DIV_W = 7;
  localparam int MAX_CH = 7;
  typedef enum logic [2:0] {IDLE, GATE, LOAD, RESET_PLL, WAIT_LOCK, UNGATE, FAIL} state_t;
  function automatic int prof_lsb(input int p, input int nch);
    return p * nch * DIV_W;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// pll_reconfig_ctrl_if: profile-change request handshake and sequencer status
interface pll_reconfig_ctrl_if #(parameter int PW = 1);
  logic          req_valid;
  logic [PW-1:0] req_profile;
  logic          req_ready;
  logic          done;
  logic          err;
  logic          busy;
  logic [PW-1:0] cur_profile;
  modport master (output req_valid, req_profile, input req_ready, done, err, busy, cur_profile);
  modport slave  (input req_valid, req_profile, output req_ready, done, err, busy, cur_profile);
endinterface

// File: rtl/pll_lock_filter.sv
// pll_lock_filter: synchronises async PLL LOCK and debounces it with consecutive-high/low counters
module pll_lock_filter #(
  parameter int LOCK_FILTER = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic lock_async,
  output logic lock_ok,
  output logic lock_lost
);
  localparam int FW = $clog2(LOCK_FILTER) + 1;
  logic [1:0]    sync;
  logic [FW-1:0] hi, lo;
  always_ff @(posedge clk)
    if (!resetn) begin
      sync <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      sync <= {sync[0], lock_async};
      hi   <= clr || !sync[1] ? '0 : hi == FW'(LOCK_FILTER) ? hi : hi + FW'(1);
      lo   <= clr || sync[1] ? '0 : lo == FW'(LOCK_FILTER) ? lo : lo + FW'(1);
    end
  assign lock_ok   = hi == FW'(LOCK_FILTER);
  assign lock_lost = lo == FW'(LOCK_FILTER);
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: Gowin PLL divider-profile sequencer (gate, load, reset, wait lock, ungate).
// Optional PLL_LOCKLOSS_RECOVER_EN: lock loss while idle re-runs the sequence on the current profile.
module pll_reconfig_ctrl import pll_cfg_pkg::*; #(
  parameter int NUM_CH       = 4,
  parameter int NUM_PROFILES = 2,
  parameter int PW           = NUM_PROFILES > 1 ? $clog2(NUM_PROFILES) : 1,
  parameter logic [NUM_PROFILES*DIV_W-1:0] MDIV_TABLE = {7'd36, 7'd36},
  parameter logic [NUM_PROFILES*NUM_CH*DIV_W-1:0] ODIV_TABLE =
    {7'd12, 7'd24, 7'd36, 7'd72, 7'd18, 7'd30, 7'd45, 7'd90},
  parameter int GATE_CYCLES  = 8,
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_FILTER  = 64,
  parameter int LOCK_TIMEOUT = 1 << 20,
  parameter int MAX_RETRY    = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  pll_reconfig_ctrl_if.slave      bus,
  input  logic                    pll_lock,
  output logic                    pll_reset,
  output logic [DIV_W-1:0]        pll_mdsel,
  output logic [NUM_CH*DIV_W-1:0] pll_odsel,
  output logic [NUM_CH-1:0]       pll_enclk,
  output logic                    sys_rstn
);
  localparam int CW = $clog2(max3(GATE_CYCLES + 1, RESET_CYCLES, LOCK_TIMEOUT)) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  state_t                  state, state_n;
  logic [CW-1:0]           cnt;
  logic [RW-1:0]           retry;
  logic [PW-1:0]           target, cur;
  logic                    done_r, err_r, bad, good, same, rec, lock_ok, lock_lost;
  logic [DIV_W-1:0]        md_sel;
  logic [NUM_CH*DIV_W-1:0] od_sel;
  pll_lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_filt (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (state == RESET_PLL),
    .lock_async (pll_lock),
    .lock_ok    (lock_ok),
    .lock_lost  (lock_lost)
  );
`ifdef PLL_LOCKLOSS_RECOVER_EN
  assign rec = lock_lost;
`else
  logic unused_lost;
  assign unused_lost = lock_lost;
  assign rec = 1'b0;
`endif
  assign bad  = int'(bus.req_profile) >= NUM_PROFILES;
  assign good = bus.req_valid && !bad;
  assign same = bus.req_profile == cur;
  always_comb begin
    md_sel = MDIV_TABLE[DIV_W-1:0];
    od_sel = ODIV_TABLE[NUM_CH*DIV_W-1:0];
    for (int p = 1; p < NUM_PROFILES; p++) begin
      md_sel = int'(target) == p ? MDIV_TABLE[prof_lsb(p, 1) +: DIV_W] : md_sel;
      od_sel = int'(target) == p ? ODIV_TABLE[prof_lsb(p, NUM_CH) +: NUM_CH*DIV_W] : od_sel;
    end
  end
  always_ff @(posedge clk)
    if (!resetn) state <= RESET_PLL;
    else         state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      state_n = good ? (same ? IDLE : GATE) : rec ? GATE : IDLE;
      GATE:      state_n = cnt == CW'(GATE_CYCLES) ? LOAD : GATE;
      LOAD:      state_n = RESET_PLL;
      RESET_PLL: state_n = cnt == CW'(RESET_CYCLES - 1) ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: state_n = lock_ok ? UNGATE : cnt != CW'(LOCK_TIMEOUT - 1) ? WAIT_LOCK :
                           retry == RW'(MAX_RETRY) ? FAIL : RESET_PLL;
      UNGATE:    state_n = IDLE;
      FAIL:      state_n = good ? GATE : FAIL;
      default:   state_n = IDLE;
    endcase
  end
  // Enable stays high through the first GATE cycle so outputs stop one cycle after accept.
  always_comb begin
    bus.req_ready = state == IDLE || state == FAIL;
    bus.busy      = state != IDLE;
    pll_reset     = state == RESET_PLL;
    pll_enclk     = state == IDLE || state == UNGATE || (state == GATE && cnt == '0) ? '1 : '0;
    sys_rstn      = state == IDLE;
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      cnt       <= '0;
      retry     <= '0;
      target    <= '0;
      cur       <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      pll_mdsel <= MDIV_TABLE[DIV_W-1:0];
      pll_odsel <= ODIV_TABLE[NUM_CH*DIV_W-1:0];
    end else begin
      cnt    <= state_n != state ? '0 : &cnt ? cnt : cnt + CW'(1);
      retry  <= state == WAIT_LOCK && state_n == RESET_PLL ? retry + RW'(1) : state_n == GATE ? '0 : retry;
      target <= state_n == GATE && state != GATE ? (good ? bus.req_profile : cur) : target;
      cur    <= state == UNGATE ? target : cur;
      done_r <= state == UNGATE || (state == IDLE && good && same);
      err_r  <= state_n == FAIL || (state == IDLE && bus.req_valid && bad);
      if (state == LOAD) begin
        pll_mdsel <= md_sel;
        pll_odsel <= od_sel;
      end
    end
  assign bus.done        = done_r;
  assign bus.err         = err_r;
  assign bus.cur_profile = cur;
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: directed vectors and multi-cycle sequences for the PLL reconfig controller
module tb_pll_reconfig_ctrl;
  localparam logic [27:0] P0_OD = {7'd18, 7'd30, 7'd45, 7'd90};
  localparam logic [27:0] P1_OD = {7'd12, 7'd24, 7'd36, 7'd72};
  localparam logic [27:0] P2_OD = {7'd10, 7'd20, 7'd30, 7'd60};
  typedef struct {
    logic       v;
    logic [1:0] p;
    logic       done, err, busy;
    logic [1:0] cur;
  } vec_t;
  logic clk = 1'b0, resetn = 1'b0, pll_lock, pll_reset, sys_rstn;
  logic [6:0]  pll_mdsel;
  logic [27:0] pll_odsel;
  logic [3:0]  pll_enclk;
  logic auto_lock = 1'b1, lock_man = 1'b0;
  int lk_cnt = 0, nvec = 0, nerr = 0;
  vec_t tv[8];
  pll_reconfig_ctrl_if #(.PW(2)) bus();
  pll_reconfig_ctrl #(
    .NUM_CH(4), .NUM_PROFILES(3), .PW(2),
    .MDIV_TABLE({7'd40, 7'd36, 7'd36}),
    .ODIV_TABLE({P2_OD, P1_OD, P0_OD}),
    .LOCK_TIMEOUT(256)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_mdsel(pll_mdsel), .pll_odsel(pll_odsel), .pll_enclk(pll_enclk), .sys_rstn(sys_rstn)
  );
  always #5 clk = ~clk;
  // PLL model: lock rises 100 cycles after RESET falls; manual override for corner cases
  always @(posedge clk) lk_cnt <= pll_reset ? 0 : (lk_cnt < 1000 ? lk_cnt + 1 : lk_cnt);
  assign pll_lock = auto_lock ? (!pll_reset && lk_cnt >= 100) : lock_man;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic sig(input int w);
    return w == 0 ? bus.done : w == 1 ? pll_reset : w == 2 ? !pll_reset : bus.err;
  endfunction
  task automatic wait_for(input int w, input int budget, input string nm);
    int n = 0;
    while (sig(w) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(sig(w)), 64'd1);
  endtask
  task automatic req(input logic [1:0] p);
    bus.req_valid = 1'b1;
    bus.req_profile = p;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  initial begin
    int first, cnt2, pulses;
    logic prev;
    tv[0] = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0};
    tv[1] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0};
    tv[2] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    tv[3] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    tv[4] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    tv[5] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0};
    tv[6] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    tv[7] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    bus.req_valid = 1'b0;
    bus.req_profile = '0;
    repeat (5) @(negedge clk);
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_enclk", pll_enclk, 0);
    chk("rst_sys_rstn", sys_rstn, 0);
    chk("rst_mdsel", pll_mdsel, 36);
    chk("rst_odsel", pll_odsel, P0_OD);
    chk("rst_cur", bus.cur_profile, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 1);
    resetn = 1'b1;
    wait_for(0, 500, "pwrup_done");
    chk("pwrup_cur", bus.cur_profile, 0);
    chk("pwrup_sys_rstn", sys_rstn, 1);
    cnt2 = 0;
    repeat (20) begin
      @(negedge clk);
      cnt2 += int'(bus.done);
    end
    chk("pwrup_extra_done", cnt2, 0);
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = tv[i].v;
      bus.req_profile = tv[i].p;
      @(negedge clk);
      chk($sformatf("vec%0d_done", i), bus.done, tv[i].done);
      chk($sformatf("vec%0d_err", i), bus.err, tv[i].err);
      chk($sformatf("vec%0d_busy", i), bus.busy, tv[i].busy);
      chk($sformatf("vec%0d_cur", i), bus.cur_profile, tv[i].cur);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_profile = 2'd1;
    first = 0;
    cnt2 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (k == 1) begin
        chk("p1_sys_rstn_accept", sys_rstn, 0);
        chk("p1_busy", bus.busy, 1);
        chk("p1_ready", bus.req_ready, 0);
      end
      if (k == 2) chk("p1_enclk_gated", pll_enclk, 0);
      if (k == 10) chk("p1_odsel_before_load", pll_odsel[6:0], 90);
      if (pll_reset && first == 0) first = k;
      if (k <= 10 && pll_enclk == 4'd0) cnt2++;
    end
    chk("p1_reset_start", first, 11);
    chk("p1_gate_len", cnt2, 9);
    chk("p1_odsel", pll_odsel, P1_OD);
    chk("p1_mdsel", pll_mdsel, 36);
    cnt2 = 2;
    for (int k = 0; k < 40 && pll_reset; k++) begin
      @(negedge clk);
      cnt2 += int'(pll_reset);
    end
    chk("p1_reset_width", cnt2, 16);
    wait_for(0, 400, "p1_done");
    chk("p1_cur", bus.cur_profile, 1);
    chk("p1_sys_rstn", sys_rstn, 1);
    chk("p1_enclk", pll_enclk, 4'hf);
    chk("p1_busy_end", bus.busy, 0);
    auto_lock = 1'b0;
    lock_man = 1'b0;
    req(2'd2);
    pulses = 0;
    prev = pll_reset;
    for (int k = 0; k < 3000 && !bus.err; k++) begin
      @(negedge clk);
      if (pll_reset && !prev) pulses++;
      prev = pll_reset;
    end
    chk("fail_err", bus.err, 1);
    chk("fail_pulses", pulses, 4);
    chk("fail_ready", bus.req_ready, 1);
    chk("fail_sys_rstn", sys_rstn, 0);
    chk("fail_enclk", pll_enclk, 0);
    chk("fail_pll_reset", pll_reset, 0);
    repeat (10) @(negedge clk);
    chk("fail_err_sticky", bus.err, 1);
    chk("fail_cur", bus.cur_profile, 1);
    auto_lock = 1'b1;
    req(2'd2);
    chk("fail_err_cleared", bus.err, 0);
    chk("fail_busy", bus.busy, 1);
    wait_for(0, 600, "p2_done");
    chk("p2_cur", bus.cur_profile, 2);
    chk("p2_mdsel", pll_mdsel, 40);
    chk("p2_odsel", pll_odsel, P2_OD);
    auto_lock = 1'b0;
    lock_man = 1'b0;
    req(2'd0);
    wait_for(1, 30, "glitch_reset_hi");
    wait_for(2, 30, "glitch_reset_lo");
    lock_man = 1'b1;
    repeat (63) @(negedge clk);
    lock_man = 1'b0;
    @(negedge clk);
    lock_man = 1'b1;
    first = 0;
    pulses = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (sys_rstn && first == 0) first = k;
      if (bus.done && pulses == 0) pulses = k;
    end
    chk("glitch_sys_rstn_k", first, 68);
    chk("glitch_done_k", pulses, 68);
    chk("glitch_cur", bus.cur_profile, 0);
    auto_lock = 1'b1;
    @(negedge clk);
    auto_lock = 1'b0;
    lock_man = 1'b0;
    req(2'd1);
    wait_for(1, 30, "rst_mid_hi");
    wait_for(2, 30, "rst_mid_lo");
    repeat (5) @(negedge clk);
    chk("rst_mid_odsel_loaded", pll_odsel[6:0], 72);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_mid_pll_reset", pll_reset, 1);
    chk("rst_mid_odsel", pll_odsel, P0_OD);
    chk("rst_mid_busy", bus.busy, 1);
    chk("rst_mid_ready", bus.req_ready, 0);
    chk("rst_mid_sys_rstn", sys_rstn, 0);
    resetn = 1'b1;
    auto_lock = 1'b1;
    wait_for(0, 500, "rst_mid_done");
    chk("rst_mid_cur", bus.cur_profile, 0);
    lock_man = 1'b1;
    auto_lock = 1'b0;
    @(negedge clk);
    lock_man = 1'b0;
`ifdef PLL_LOCKLOSS_RECOVER_EN
    first = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (bus.busy && first == 0) first = k;
    end
    chk("recover_start_k", first, 67);
    chk("recover_sys_rstn", sys_rstn, 0);
    auto_lock = 1'b1;
    wait_for(0, 600, "recover_done");
    chk("recover_cur", bus.cur_profile, 0);
    chk("recover_sys_rstn_end", sys_rstn, 1);
`else
    cnt2 = 0;
    repeat (100) begin
      @(negedge clk);
      cnt2 += int'(bus.busy || !sys_rstn);
    end
    chk("lockloss_ignored", cnt2, 0);
    lock_man = 1'b1;
    auto_lock = 1'b1;
`endif
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
